seven_segment_scan: RTL

Time-multiplexed driver for a DIGITS-wide common-anode/cathode seven-segment display, successor to the single-digit 3-bit decoder. Decodes full hex (0–F) per digit, scans digits with a programmable refresh prescaler, supports per-digit decimal points, leading-zero suppression and global blanking. Sits between the 8×8 multiplier result register and the board display pins; the default 4 digits show the 16-bit product.

---
 rtl/seven_segment_pkg.sv | 36 +++
 rtl/hex_to_seg.sv | 11 +
 rtl/seven_segment_scan.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants for the multiplexed seven-segment driver: the hex glyph
// table, the all-segments-off pattern and the segment bit positions.
package seven_segment_pkg;

  // Segment order on the seg bus is {a,b,c,d,e,f,g}, so a is the MSB.
  localparam int SEG_W     = 7;
  localparam int SEG_A_BIT = 6;
  localparam int SEG_G_BIT = 0;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'b000_0000;

  // Active-high glyphs; entry n is the pattern for hex digit n.
  localparam logic [15:0][SEG_W-1:0] GLYPH_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic logic [SEG_W-1:0] glyph_of(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment glyph.
module hex_to_seg
  import seven_segment_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] glyph
);

  assign glyph = glyph_of(nibble);

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed seven-segment driver. A prescaler paces the digit scan,
// new values are staged in a shadow register and only copied to the display
// register at a frame boundary so a frame never mixes old and new digits.
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 0,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam bit INV = (ACTIVE_LOW != 0);

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         index;
  logic [4*DIGITS-1:0]   shadow_value;
  logic [DIGITS-1:0]     shadow_dp;
  logic [4*DIGITS-1:0]   display_value;
  logic [DIGITS-1:0]     display_dp;

  logic                  tick;
  logic                  frame_end;
  logic [DIGITS-1:0]     lead_zero;
  logic                  upper_zero;
  logic [3:0]            sel_nibble;
  logic                  sel_dp;
  logic                  sel_lz;
  logic [SEG_W-1:0]      sel_glyph;
  logic [SEG_W-1:0]      next_seg;
  logic                  next_dp;
  logic [DIGITS-1:0]     next_an;

  assign tick      = (prescaler == PRE_MAX);
  assign frame_end = tick && (index == IDX_MAX);

  // Prescaler paces the scan; the digit index advances once per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      index     <= '0;
    end else if (tick) begin
      prescaler <= '0;
      index     <= (index == IDX_MAX) ? '0 : index + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Shadow captures loads; display only takes the shadow at a frame boundary.
  // A load landing on the commit edge still wins the shadow and keeps pending
  // set, while the display takes the previously staged value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value  <= '0;
      shadow_dp     <= '0;
      display_value <= '0;
      display_dp    <= '0;
      pending       <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        display_value <= shadow_value;
        display_dp    <= shadow_dp;
      end
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
        pending      <= 1'b1;
      end else if (frame_end) begin
        pending      <= 1'b0;
      end
    end
  end

  // A digit above 0 is a leading zero when it and every higher nibble are 0.
  always_comb begin
    lead_zero  = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (display_value[i*4 +: 4] == 4'd0);
      if ((LZ_SUPPRESS != 0) && (i > 0)) lead_zero[i] = upper_zero;
    end
  end

  // Pick the nibble, decimal point and suppression flag of the active digit.
  always_comb begin
    sel_nibble = '0;
    sel_dp     = 1'b0;
    sel_lz     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (index == IW'(i)) begin
        sel_nibble = display_value[i*4 +: 4];
        sel_dp     = display_dp[i];
        sel_lz     = lead_zero[i];
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble (sel_nibble),
    .glyph  (sel_glyph)
  );

  // Active-high next outputs. A leading-zero digit with its decimal point set
  // stays enabled so the point is visible, but its segments are dark.
  always_comb begin
    next_an  = '0;
    next_seg = (blank || sel_lz) ? SEG_OFF : sel_glyph;
    next_dp  = !blank && sel_dp;
    for (int i = 0; i < DIGITS; i++) begin
      next_an[i] = (index == IW'(i)) && !blank && !(sel_lz && !sel_dp);
    end
  end

  // Output registers; polarity inversion happens only here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= {SEG_W{INV}};
      dp  <= INV;
      an  <= {DIGITS{INV}};
    end else begin
      seg <= next_seg ^ {SEG_W{INV}};
      dp  <= next_dp ^ INV;
      an  <= next_an ^ {DIGITS{INV}};
    end
  end

endmodule
